// File: rtl/blink_monitor.sv
// Measures the half-period of a slow asynchronous blink signal and reports lock/timeout status.
// Optional BLINK_MON_COUNT_EN puts a wrapping 5-bit count of period_valid pulses on leds[7:3].
module blink_monitor #(
    parameter int unsigned CLK_FREQ = 25_000_000,
    parameter int unsigned TOL_DIV  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        blink_in,
    output logic [31:0] half_period,
    output logic        period_valid,
    output logic        locked,
    output logic        timeout,
    output logic [7:0]  leds
);

    localparam logic [31:0] NOMINAL = 32'(CLK_FREQ / 2);
    localparam logic [31:0] TOL     = NOMINAL / 32'(TOL_DIV);
    localparam logic [31:0] LIMIT   = 32'(CLK_FREQ);
    localparam logic [31:0] TOL_LO  = NOMINAL - TOL;
    localparam logic [31:0] TOL_HI  = NOMINAL + TOL;

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t      state;
    logic        sync1;
    logic        sync2;
    logic        sync3;
    logic [31:0] cnt;
    logic [1:0]  good;

    logic        blink_edge;
    logic [31:0] meas;
    logic        in_tol;
    logic [1:0]  good_next;

    assign blink_edge = sync2 ^ sync3;
    assign meas       = cnt + 32'd1;
    assign in_tol     = (meas >= TOL_LO) && (meas <= TOL_HI);
    assign good_next  = !in_tol ? 2'd0 : ((good == 2'd2) ? 2'd2 : good + 2'd1);

    // sync1/sync2 resolve metastability; sync3 is the previous sample for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= blink_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 32'd0;
            good         <= 2'd0;
            half_period  <= 32'd0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (blink_edge) begin
                        cnt     <= 32'd0;
                        timeout <= 1'b0;
                        state   <= MEASURE;
                    end
                end
                MEASURE: begin
                    // An edge arriving on the last counted cycle still counts as a measurement
                    if (blink_edge) begin
                        half_period  <= meas;
                        period_valid <= 1'b1;
                        good         <= good_next;
                        locked       <= (good_next == 2'd2);
                        cnt          <= 32'd0;
                    end else if (cnt == LIMIT - 32'd1) begin
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                        good    <= 2'd0;
                        cnt     <= 32'd0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BLINK_MON_COUNT_EN
    logic [4:0] pv_count;

    // Counts alongside the measurement so leds[7:3] changes in the same cycle as period_valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv_count <= 5'd0;
        end else if (state == MEASURE && blink_edge) begin
            pv_count <= pv_count + 5'd1;
        end
    end

    assign leds = {pv_count, timeout, locked, sync2};
`else
    assign leds = {5'd0, timeout, locked, sync2};
`endif

endmodule

// File: tb/tb_blink_monitor.sv
// Randomized and directed bench for blink_monitor, checked against an edge-timestamp model.
module tb_blink_monitor;

    localparam int CF    = 16;
    localparam int TD    = 8;
    localparam int NOM   = CF / 2;
    localparam int TOLC  = NOM / TD;
    localparam int LIMIT = CF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        blink_in = 1'b0;
    logic [31:0] half_period;
    logic        period_valid;
    logic        locked;
    logic        timeout;
    logic [7:0]  leds;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: input seen through a fixed delay, edges timestamped in cycles
    int          cyc = 0;
    int          last_edge = 0;
    int          consec = 0;
    int          pvcount = 0;
    bit          in_meas = 0;
    bit [2:0]    dly = 3'b000;
    logic [31:0] exp_hp = 0;
    logic        exp_pv = 0;
    logic        exp_locked = 0;
    logic        exp_to = 0;
    logic [7:0]  exp_leds = 0;

    wire  [42:0] dut_vec = {half_period, period_valid, locked, timeout, leds};
    logic [42:0] exp_vec;

    blink_monitor #(.CLK_FREQ(CF), .TOL_DIV(TD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .blink_in(blink_in),
        .half_period(half_period),
        .period_valid(period_valid),
        .locked(locked),
        .timeout(timeout),
        .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit e;
        int m;
        logic [4:0] c5;
        cyc++;
        if (!rst_n) begin
            dly = 3'b000; in_meas = 0; consec = 0; pvcount = 0;
            exp_hp = 0; exp_pv = 0; exp_locked = 0; exp_to = 0;
        end else begin
            e = dly[1] != dly[2];
            exp_pv = 0;
            if (!in_meas) begin
                if (e) begin
                    in_meas = 1; last_edge = cyc; exp_to = 0;
                end
            end else if (e) begin
                m = cyc - last_edge;
                exp_hp = 32'(m);
                exp_pv = 1;
                pvcount = (pvcount + 1) % 32;
                if (m >= NOM - TOLC && m <= NOM + TOLC) consec++;
                else consec = 0;
                exp_locked = (consec >= 2);
                last_edge = cyc;
            end else if (cyc - last_edge == LIMIT) begin
                exp_to = 1; exp_locked = 0; consec = 0; in_meas = 0;
            end
            dly = {dly[1:0], blink_in};
        end
`ifdef BLINK_MON_COUNT_EN
        c5 = 5'(pvcount);
`else
        c5 = 5'd0;
`endif
        exp_leds = {c5, exp_to, exp_locked, dly[1]};
        exp_vec = {exp_hp, exp_pv, exp_locked, exp_to, exp_leds};
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        int pulses = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            blink_in = ~blink_in;
            tick();
            vectors++;
            if (dut_vec !== 43'd0) begin
                miscompares++;
                $display("FAIL reset_outputs cyc=%0d got=%h want=0", cyc, dut_vec);
            end
        end
        // Input held high across release: the edge is absorbed by IDLE
        blink_in = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (period_valid) pulses++;
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL release_high cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
            end
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL release_high_pulses got=%0d want=0", pulses);
        end
    endtask

    task automatic test_lock();
        int          holds[6] = '{8, 8, 10, 7, 7, 4};
        logic [31:0] want_hp[5] = '{32'd8, 32'd8, 32'd10, 32'd7, 32'd7};
        logic        want_lk[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] got_hp[$];
        logic        got_lk[$];
        rst_n = 1'b0; blink_in = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            blink_in = ~blink_in;
            for (int j = 0; j < holds[i]; j++) begin
                tick();
                if (period_valid) begin
                    got_hp.push_back(half_period);
                    got_lk.push_back(locked);
                end
                vectors++;
                if (dut_vec !== exp_vec) begin
                    miscompares++;
                    $display("FAIL lock_trace cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
                end
            end
        end
        vectors++;
        if (got_hp.size() != 5) begin
            miscompares++;
            $display("FAIL lock_pulse_count got=%0d want=5", got_hp.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                vectors++;
                if (got_hp[k] !== want_hp[k] || got_lk[k] !== want_lk[k]) begin
                    miscompares++;
                    $display("FAIL lock_pulse%0d got hp=%0d lk=%b want hp=%0d lk=%b",
                             k, got_hp[k], got_lk[k], want_hp[k], want_lk[k]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL timeout_trace cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
            end
        end
        vectors++;
        if (timeout !== 1'b1 || locked !== 1'b0 || half_period !== 32'd7) begin
            miscompares++;
            $display("FAIL timeout_state got to=%b lk=%b hp=%0d want to=1 lk=0 hp=7",
                     timeout, locked, half_period);
        end
        blink_in = ~blink_in;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (period_valid) pulses++;
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL timeout_clear cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
            end
        end
        vectors++;
        if (timeout !== 1'b0 || pulses !== 0) begin
            miscompares++;
            $display("FAIL timeout_release got to=%b pulses=%0d want to=0 pulses=0", timeout, pulses);
        end
    endtask

    task automatic test_edge_at_limit();
        int  holds[2] = '{16, 4};
        bit  saw_to = 0;
        for (int i = 0; i < 2; i++) begin
            blink_in = ~blink_in;
            for (int j = 0; j < holds[i]; j++) begin
                tick();
                if (timeout) saw_to = 1;
                vectors++;
                if (dut_vec !== exp_vec) begin
                    miscompares++;
                    $display("FAIL limit_trace cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
                end
            end
        end
        vectors++;
        if (half_period !== 32'd16 || saw_to) begin
            miscompares++;
            $display("FAIL edge_at_limit got hp=%0d to_seen=%b want hp=16 to_seen=0", half_period, saw_to);
        end
    endtask

    task automatic test_random();
        int r;
        int h;
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 24);
            if (r == 0) begin
                rst_n = 1'b0;
                h = $urandom_range(1, 2);
                for (int j = 0; j < h; j++) begin
                    blink_in = 1'($urandom_range(0, 1));
                    tick();
                end
                rst_n = 1'b1;
                continue;
            end
            blink_in = ~blink_in;
            h = (r < 12) ? $urandom_range(NOM - TOLC - 1, NOM + TOLC + 1) : $urandom_range(1, 20);
            for (int j = 0; j < h; j++) begin
                tick();
                vectors++;
                if (dut_vec !== exp_vec) begin
                    miscompares++;
                    $display("FAIL random cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
                end
            end
        end
    endtask

    task automatic test_counter();
        logic [4:0] want;
`ifdef BLINK_MON_COUNT_EN
        want = 5'd1;
`else
        want = 5'd0;
`endif
        rst_n = 1'b0; blink_in = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        // 34 edges give 33 measurements
        for (int i = 0; i < 34; i++) begin
            blink_in = ~blink_in;
            for (int j = 0; j < NOM; j++) begin
                tick();
                vectors++;
                if (dut_vec !== exp_vec) begin
                    miscompares++;
                    $display("FAIL counter_trace cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
                end
            end
        end
        vectors++;
        if (leds[7:3] !== want) begin
            miscompares++;
            $display("FAIL pulse_counter got=%0d want=%0d", leds[7:3], want);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_timeout();
        test_edge_at_limit();
        test_random();
        test_counter();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/blink_monitor.md
BLINK_MONITOR -- requirements
Module: blink_monitor

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter TOL_DIV, default 8, meaning tolerance divisor: TOL = (CLK_FREQ/2)/TOL_DIV cycles.
REQ-003 Port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 Port rst_n, input, 1, reset; synchronous and active-low.
REQ-005 Port blink_in, input, 1, remote blink signal, asynchronous to clk.
REQ-006 Port half_period, output, 32, cycles between the last two accepted edges.
REQ-007 Port period_valid, output, 1, single-cycle pulse when half_period updates.
REQ-008 Port locked, output, 1, blink rate within tolerance of the nominal half second.
REQ-009 Port timeout, output, 1, no edge seen for CLK_FREQ cycles.
REQ-010 Port leds, output, 8, status display.

Function
REQ-011 blink_in SHALL pass a 2-flop synchronizer, then a third flop; edge = sync2 XOR sync3, so the edge is detected 3 cycles after the input change.
REQ-012 Derived constants: NOMINAL = CLK_FREQ/2; TOL = NOMINAL/TOL_DIV (integer division); LIMIT = CLK_FREQ.
REQ-013 FSM states: IDLE (wait for first edge) and MEASURE (counting since last edge).
REQ-014 IDLE + edge: cnt <= 0, go to MEASURE, no period_valid.
REQ-015 In MEASURE: 32-bit cnt increments every cycle without an edge.
REQ-016 MEASURE + edge: half_period <= cnt+1, period_valid = 1 next cycle for exactly 1 cycle, cnt <= 0, stay in MEASURE.
REQ-017 Measurement M is in tolerance iff NOMINAL-TOL <= M <= NOMINAL+TOL, inclusive, compared unsigned at 32 bits.
REQ-018 2-bit good counter: +1 on an in-tolerance measurement, saturating at 2; cleared on an out-of-tolerance measurement.
REQ-019 locked SHALL be 1 while good = 2 and 0 otherwise; it updates in the same cycle as period_valid.
REQ-020 MEASURE with cnt = LIMIT-1 and no edge: timeout <= 1, locked <= 0, good <= 0, cnt <= 0, go to IDLE.
REQ-021 If an edge and cnt = LIMIT-1 occur in the same cycle, the edge wins: measurement taken per REQ-016, no timeout.
REQ-022 timeout SHALL stay 1 until the next detected edge, and clear in the cycle after that edge.
REQ-023 leds[0] = sync2 (mirrors the input), leds[1] = locked, leds[2] = timeout; leds[7:3] per REQ-029/030.
REQ-024 half_period SHALL hold its value between updates, including through timeout.

Reset
REQ-025 When rst_n = 0 at posedge clk: FSM = IDLE; cnt, good, and sync/edge flops = 0.
REQ-026 Reset values: half_period = 0, period_valid = 0, locked = 0, timeout = 0, leds = 8'h00.
REQ-027 Reset mid-measurement SHALL abandon the measurement; the first edge after release is handled per REQ-014.
REQ-028 An input held high at reset release yields one detected edge, consumed by IDLE (no period_valid).

Configuration
REQ-029 With BLINK_MON_COUNT_EN defined: leds[7:3] = 5-bit counter of period_valid pulses, wrapping 31 -> 0, reset to 0.
REQ-030 Without BLINK_MON_COUNT_EN: leds[7:3] = 0 constantly, and no counter logic is built.

Verification (CLK_FREQ=16 -> NOMINAL=8, TOL=1, LIMIT=16; TOL_DIV=8)
REQ-031 Reset: hold rst_n=0 2 cycles with blink_in toggling -> all outputs 0, leds = 8'h00.
REQ-032 Toggle blink_in every 8 cycles -> no pulse on edge 1; half_period = 8 with period_valid on edges 2 and 3; locked = 1 after edge 3.
REQ-033 After lock, one half-period of 10 cycles -> half_period = 10, locked = 0; then two 7-cycle halves -> locked = 1.
REQ-034 After an edge, hold blink_in 16+ cycles -> timeout = 1 and locked = 0 at cnt = 15; the next edge clears timeout with no period_valid.
REQ-035 Edge and cnt = 15 in the same cycle -> half_period = 16, period_valid = 1, timeout stays 0.
REQ-036 With BLINK_MON_COUNT_EN, 33 period_valid pulses -> leds[7:3] = 5'd1; without the macro -> leds[7:3] = 0.
